// File: rtl/manta_bus_pkg.sv
// Shared types and helpers for the Manta bus arbiter slice.
// Included by manta_rr_arbiter and manta_bus_arbiter.
package manta_bus_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // Width needed to index v items; never less than 1 bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/manta_rr_arbiter.sv
// Combinational round-robin grant: first valid requester after ptr_i, wrapping.
// The pointer register lives in the parent.
module manta_rr_arbiter
    import manta_bus_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   grant_idx_o,
    output logic               any_o
);

    int unsigned idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        idx         = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = 32'(ptr_i) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any_o && valid_i[PTR_W'(idx)]) begin
                grant_o[PTR_W'(idx)] = 1'b1;
                grant_idx_o          = PTR_W'(idx);
                any_o                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/manta_bus_arbiter.sv
// Round-robin arbiter sharing one Manta core chain among NUM_REQ hosts, one transaction in flight.
// Optional WAIT-state timeout enabled by defining MANTA_ARB_TIMEOUT_EN.
module manta_bus_arbiter
    import manta_bus_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]        req_rw_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]         resp_data_o,
    output logic [NUM_REQ-1:0]        resp_valid_o,
    output logic [ADDR_W-1:0]         bus_addr_o,
    output logic [DATA_W-1:0]         bus_data_o,
    output logic                      bus_rw_o,
    output logic                      bus_valid_o,
    input  logic [DATA_W-1:0]         bus_data_i,
    input  logic                      bus_rw_i,
    input  logic                      bus_valid_i,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int unsigned PTR_W = clog2(NUM_REQ);

    arb_state_t state_q, state_d;

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]  bus_data_q, bus_data_d;
    logic               bus_rw_q, bus_rw_d;
    logic               bus_valid_q, bus_valid_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]  resp_data_q, resp_data_d;
    logic               timeout_q, timeout_d;
    logic               to_expire;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;

    logic [ADDR_W-1:0]  req_addr_a [NUM_REQ];
    logic [DATA_W-1:0]  req_data_a [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_addr_a[k] = req_addr_i[k*ADDR_W +: ADDR_W];
        assign req_data_a[k] = req_data_i[k*DATA_W +: DATA_W];
    end

    manta_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .valid_i     (req_valid_i),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

`ifdef MANTA_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;

    // Cleared while in ISSUE so the first WAIT cycle sees zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            cnt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign to_expire = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign to_expire      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= PTR_W'(NUM_REQ - 1);
            owner_q      <= '0;
            bus_addr_q   <= '0;
            bus_data_q   <= '0;
            bus_rw_q     <= 1'b0;
            bus_valid_q  <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            bus_addr_q   <= bus_addr_d;
            bus_data_q   <= bus_data_d;
            bus_rw_q     <= bus_rw_d;
            bus_valid_q  <= bus_valid_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_any) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (bus_valid_i || to_expire) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Echoes arriving outside WAIT are ignored; echo beats expiry in the same cycle.
    always_comb begin
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        bus_addr_d   = bus_addr_q;
        bus_data_d   = bus_data_q;
        bus_rw_d     = bus_rw_q;
        bus_valid_d  = 1'b0;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        timeout_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    ptr_d       = grant_idx;
                    owner_d     = grant_idx;
                    bus_addr_d  = req_addr_a[grant_idx];
                    bus_data_d  = req_data_a[grant_idx];
                    bus_rw_d    = req_rw_i[grant_idx];
                    bus_valid_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus_valid_i) begin
                    if (!bus_rw_i) begin
                        resp_valid_d[owner_q] = 1'b1;
                        resp_data_d           = bus_data_i;
                    end
                end else if (to_expire) begin
                    timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign req_ready_o  = (state_q == ST_IDLE && rst_n) ? grant : '0;
    assign resp_data_o  = resp_data_q;
    assign resp_valid_o = resp_valid_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_data_o   = bus_data_q;
    assign bus_rw_o     = bus_rw_q;
    assign bus_valid_o  = bus_valid_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_manta_bus_arbiter.sv
// Scoreboard bench for manta_bus_arbiter; the timeout scenario runs only when
// MANTA_ARB_TIMEOUT_EN is defined.
module tb_manta_bus_arbiter;

    localparam int KBUS  = 0;
    localparam int KRESP = 1;
    localparam int KTMO  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_rw = '0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready_o;
    logic [15:0] resp_data_o;
    logic [1:0]  resp_valid_o;
    logic [15:0] bus_addr_o;
    logic [15:0] bus_data_o;
    logic        bus_rw_o;
    logic        bus_valid_o;
    logic [15:0] bus_data_i = '0;
    logic        bus_rw_i = 1'b0;
    logic        bus_valid_i = 1'b0;
    logic        busy_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;
        logic [1:0]  v;
        logic [15:0] a;
        logic [15:0] d;
        logic        rw;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    manta_bus_arbiter #(
        .NUM_REQ (2),
        .ADDR_W  (16),
        .DATA_W  (16),
        .TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .req_rw_i     (req_rw),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready_o),
        .resp_data_o  (resp_data_o),
        .resp_valid_o (resp_valid_o),
        .bus_addr_o   (bus_addr_o),
        .bus_data_o   (bus_data_o),
        .bus_rw_o     (bus_rw_o),
        .bus_valid_o  (bus_valid_o),
        .bus_data_i   (bus_data_i),
        .bus_rw_i     (bus_rw_i),
        .bus_valid_i  (bus_valid_i),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_bus(input logic [15:0] a, input logic [15:0] d, input logic rw);
        exp_t e;
        e.kind = KBUS; e.v = '0; e.a = a; e.d = d; e.rw = rw;
        sb.push_back(e);
    endtask

    task automatic push_resp(input logic [1:0] v, input logic [15:0] d);
        exp_t e;
        e.kind = KRESP; e.v = v; e.a = '0; e.d = d; e.rw = 1'b0;
        sb.push_back(e);
    endtask

    task automatic push_tmo();
        exp_t e;
        e.kind = KTMO; e.v = '0; e.a = '0; e.d = '0; e.rw = 1'b0;
        sb.push_back(e);
    endtask

    task automatic set_req(input int k, input logic [15:0] a, input logic [15:0] d, input logic rw);
        req_addr[k*16 +: 16] = a;
        req_data[k*16 +: 16] = d;
        req_rw[k]            = rw;
    endtask

    // Waits (bounded) for an accept, checks the one-hot grant, returns in the ISSUE cycle.
    task automatic wait_ready(input logic [1:0] exp_oh);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_ready_o != 2'b00) break;
        end
        check("ready_grant", {30'd0, req_ready_o}, {30'd0, exp_oh});
        @(posedge clk);
        #1;
        check("issue_bus_valid", {31'd0, bus_valid_o}, 32'd1);
        check("issue_busy", {31'd0, busy_o}, 32'd1);
        check("issue_ready_low", {30'd0, req_ready_o}, 32'd0);
    endtask

    // From the ISSUE cycle: wait dly edges, then present the echo for one edge.
    task automatic echo(input int dly, input logic rw, input logic [15:0] d);
        repeat (dly) @(posedge clk);
        #1;
        bus_valid_i = 1'b1;
        bus_rw_i    = rw;
        bus_data_i  = d;
        @(posedge clk);
        #1;
        bus_valid_i = 1'b0;
    endtask

    task automatic stray_pulse(input logic [15:0] d);
        bus_valid_i = 1'b1;
        bus_rw_i    = 1'b0;
        bus_data_i  = d;
        @(posedge clk);
        #1;
        bus_valid_i = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus_valid_o) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL bus_unexpected: got addr 0x%0h, expected no transaction", bus_addr_o);
                    end else begin
                        e = sb.pop_front();
                        check("bus_event_kind", 32'(KBUS), 32'(e.kind));
                        check("bus_addr", {16'd0, bus_addr_o}, {16'd0, e.a});
                        check("bus_data", {16'd0, bus_data_o}, {16'd0, e.d});
                        check("bus_rw", {31'd0, bus_rw_o}, {31'd0, e.rw});
                    end
                end
                if (resp_valid_o != 2'b00) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL resp_unexpected: got valid 0x%0h, expected none", resp_valid_o);
                    end else begin
                        e = sb.pop_front();
                        check("resp_event_kind", 32'(KRESP), 32'(e.kind));
                        check("resp_owner", {30'd0, resp_valid_o}, {30'd0, e.v});
                        check("resp_data", {16'd0, resp_data_o}, {16'd0, e.d});
                    end
                end
                if (timeout_o) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL timeout_unexpected: got 1, expected 0");
                    end else begin
                        e = sb.pop_front();
                        check("timeout_event_kind", 32'(KTMO), 32'(e.kind));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        #1;
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_bus_valid", {31'd0, bus_valid_o}, 32'd0);
        check("rst_resp_valid", {30'd0, resp_valid_o}, 32'd0);
        check("rst_timeout", {31'd0, timeout_o}, 32'd0);
        check("rst_bus_addr", {16'd0, bus_addr_o}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single read from req0
        set_req(0, 16'h0012, 16'h0000, 1'b0);
        push_bus(16'h0012, 16'h0000, 1'b0);
        push_resp(2'b01, 16'hBEEF);
        req_valid = 2'b01;
        wait_ready(2'b01);
        req_valid = 2'b00;
        echo(3, 1'b0, 16'hBEEF);
        check("t1_busy_after_echo", {31'd0, busy_o}, 32'd0);
        check("t1_resp_valid", {30'd0, resp_valid_o}, 32'd1);
        @(posedge clk);
        #1;
        check("t1_resp_pulse_end", {30'd0, resp_valid_o}, 32'd0);

        // 2: write from req1, silent completion
        set_req(1, 16'h0004, 16'h00AA, 1'b1);
        push_bus(16'h0004, 16'h00AA, 1'b1);
        req_valid = 2'b10;
        wait_ready(2'b10);
        req_valid = 2'b00;
        echo(2, 1'b1, 16'h00AA);
        check("t2_busy_after_echo", {31'd0, busy_o}, 32'd0);
        @(posedge clk);
        #1;
        check("t2_no_resp", {30'd0, resp_valid_o}, 32'd0);

        // 3: both hold valid, grants alternate 0,1,0,1
        set_req(0, 16'h0100, 16'h0000, 1'b0);
        set_req(1, 16'h0200, 16'h0000, 1'b0);
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            logic [1:0] oh;
            oh = (t % 2 == 0) ? 2'b01 : 2'b10;
            push_bus((t % 2 == 0) ? 16'h0100 : 16'h0200, 16'h0000, 1'b0);
            push_resp(oh, 16'h1000 + 16'(t));
            wait_ready(oh);
            echo(1 + t, 1'b0, 16'h1000 + 16'(t));
            check("t3_resp_owner_only", {30'd0, resp_valid_o}, {30'd0, oh});
        end
        req_valid = 2'b00;
        @(posedge clk);
        #1;

        // 4: stray echoes in IDLE and ISSUE are dropped
        stray_pulse(16'hDEAD);
        check("t4_idle_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk);
        #1;
        check("t4_idle_no_resp", {30'd0, resp_valid_o}, 32'd0);
        set_req(0, 16'h0033, 16'h0000, 1'b0);
        push_bus(16'h0033, 16'h0000, 1'b0);
        push_resp(2'b01, 16'h5555);
        req_valid = 2'b01;
        wait_ready(2'b01);
        req_valid = 2'b00;
        stray_pulse(16'hDEAD);
        check("t4_issue_still_busy", {31'd0, busy_o}, 32'd1);
        check("t4_issue_no_resp", {30'd0, resp_valid_o}, 32'd0);
        echo(1, 1'b0, 16'h5555);
        check("t4_real_resp", {30'd0, resp_valid_o}, 32'd1);
        @(posedge clk);
        #1;

`ifdef MANTA_ARB_TIMEOUT_EN
        // 5: timeout after 8 WAIT cycles, then recovery, then echo on expiry cycle
        set_req(1, 16'h0044, 16'h0000, 1'b0);
        push_bus(16'h0044, 16'h0000, 1'b0);
        push_tmo();
        req_valid = 2'b10;
        wait_ready(2'b10);
        req_valid = 2'b00;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("t5_no_early_timeout", {31'd0, timeout_o}, 32'd0);
            check("t5_waiting_busy", {31'd0, busy_o}, 32'd1);
        end
        @(posedge clk);
        #1;
        check("t5_timeout_pulse", {31'd0, timeout_o}, 32'd1);
        check("t5_idle_after_timeout", {31'd0, busy_o}, 32'd0);
        check("t5_no_resp_on_timeout", {30'd0, resp_valid_o}, 32'd0);
        set_req(0, 16'h0055, 16'h0000, 1'b0);
        push_bus(16'h0055, 16'h0000, 1'b0);
        push_resp(2'b01, 16'h7777);
        req_valid = 2'b01;
        wait_ready(2'b01);
        req_valid = 2'b00;
        echo(2, 1'b0, 16'h7777);
        set_req(1, 16'h0056, 16'h0000, 1'b0);
        push_bus(16'h0056, 16'h0000, 1'b0);
        push_resp(2'b10, 16'h8888);
        req_valid = 2'b10;
        wait_ready(2'b10);
        req_valid = 2'b00;
        echo(8, 1'b0, 16'h8888);
        check("t5_echo_wins", {31'd0, timeout_o}, 32'd0);
        check("t5_echo_resp", {30'd0, resp_valid_o}, 32'd2);
        @(posedge clk);
        #1;
`endif

        // 6: asynchronous reset during WAIT
        set_req(0, 16'h0066, 16'h1234, 1'b0);
        push_bus(16'h0066, 16'h1234, 1'b0);
        req_valid = 2'b01;
        wait_ready(2'b01);
        req_valid = 2'b00;
        @(posedge clk);
        #2;
        set_req(1, 16'h0077, 16'h0000, 1'b0);
        req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", {31'd0, busy_o}, 32'd0);
        check("t6_rst_bus_addr", {16'd0, bus_addr_o}, 32'd0);
        check("t6_rst_bus_data", {16'd0, bus_data_o}, 32'd0);
        check("t6_rst_ready", {30'd0, req_ready_o}, 32'd0);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stray_pulse(16'hCAFE);
        check("t6_post_rst_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk);
        #1;
        check("t6_post_rst_no_resp", {30'd0, resp_valid_o}, 32'd0);
        push_bus(16'h0066, 16'h1234, 1'b0);
        push_resp(2'b01, 16'h4321);
        req_valid = 2'b11;
        wait_ready(2'b01);
        req_valid = 2'b00;
        echo(1, 1'b0, 16'h4321);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
